alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised EX-stage unit: decodes OpCode/Funct, executes the op and registers the result (1-cycle latency).
//  Adds iterative mult/div with HI/LO registers, variable shifts and an issue/busy handshake for stalls.
//  Sits between the ID/EX pipeline register and the EX/MEM register; in_ready drives the hazard/stall unit.
// PARAMETERS
//  WIDTH     32  datapath width in bits; even, >=8; SHAMT_W = $clog2(WIDTH) is a localparam
//  MUL_ITER  1   1: shift-add multiply, WIDTH cycles; 0: single-cycle '*' multiply, 1 busy cycle
// PORTS
//  clk        in   1        rising-edge clock (single clock domain)
//  reset      in   1        synchronous, active-high reset
//  flush      in   1        kill current issue and abort in-flight mult/div
//  in_valid   in   1        operation presented this cycle
//  in_ready   out  1        = !md_busy; an op issues when in_valid && in_ready
//  in_opcode  in   6        instruction[31:26]
//  in_funct   in   6        instruction[5:0]
//  in_shamt   in   SHAMT_W  shift amount for sll/srl/sra
//  in_a       in   WIDTH    rs operand (forwarded)
//  in_b       in   WIDTH    rt or extended immediate
//  out_valid  out  1        out_result valid; pulses 1 cycle after issue of a GPR-writing op
//  out_result out  WIDTH    registered result
//  out_ovf    out  1        signed overflow, qualified by out_valid (see CONFIGURATION)
// BEHAVIOUR
//  Reset: out_valid=0, out_result=0, out_ovf=0, HI=LO=0, md_busy=0 (in_ready=1); aborts any mult/div.
//  Decode: lw/lb/sw(23/20/2b)->ADD; addi(08)/addiu(09)->ADD; andi(0c)->AND; slti(0a)/sltiu(0b)->SLT s/u.
//   lui(0f): result = {in_b[WIDTH/2-1:0], WIDTH/2 zeros}. beq(04)->SUB. opcode 00 uses funct:
//   20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2a/2b slt s/u,
//   00/02/03 sll/srl/sra by in_shamt, 04/06/07 sllv/srlv/srav by in_a[SHAMT_W-1:0] (shift in_b),
//   08/09 jr/jalr->ADD, 10 mfhi, 12 mflo, 11 mthi, 13 mtlo, 18/19 mult/multu, 1a/1b div/divu.
//  Undecoded ops: out_valid=1, out_result=0 (never holds a stale value).
//  Single-cycle ops: issue at T -> out_valid=1, out_result at T+1. mthi/mtlo write HI/LO at T+1, out_valid=0.
//  Mult/div: issue at T -> md_busy=1 from T+1; HI/LO written at last busy cycle; out_valid=0.
//   mult: {HI,LO} = 2*WIDTH-bit product (signed/unsigned by funct).
//   div: LO=quotient, HI=remainder, truncating toward zero; remainder takes sign of dividend.
//   divide by zero: LO = all ones, HI = dividend; signed MIN/-1: LO = MIN, HI = 0.
//  mfhi/mflo issued the cycle after md_busy falls read the new HI/LO (no bypass needed).
//  flush: suppresses same-cycle issue (no out_valid, no HI/LO write); if md_busy, aborts next edge,
//   HI/LO keep pre-op values, in_ready=1 next cycle. flush has priority over in_valid.
//  in_valid while !in_ready: ignored, upstream must hold. reset mid mult/div behaves as abort.
//  SLT: result is 0/1 zero-extended. Shift amounts >= WIDTH cannot occur (SHAMT_W bits).
// CONFIGURATION
//  ALU_OVF_EXC_EN defined: out_ovf=1 with out_valid for signed add/sub/addi overflow; result still
//   driven (wrap-around); writeback suppression is the exception unit's job.
//  Not defined: out_ovf tied 0; no overflow logic synthesised.
// STRUCTURE
//  alu_pkg: ALU op enum (ADD,SUB,AND,OR,XOR,NOR,SLL,SRL,SRA,SLT,LUI,MFHI,MFLO,MTHI,MTLO,MUL,DIV,NOP),
//   OP_*/FN_* opcode/funct localparams; shared with control unit.
//  Sub-module alu_muldiv_iter: start/signed/is_div in, busy/done/hi/lo out, abort on flush|reset.
//  Top: combinational decode + ALU, output register, HI/LO registers, handshake.
// TESTING
//  add 0x7FFFFFFF+1 (funct 20), WIDTH=32 -> T+1 result 0x80000000; out_ovf=1 only with ALU_OVF_EXC_EN.
//  srav in_a=4, in_b=0x80000000 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt same -> 0.
//  mult -3*5, then mflo/mfhi: in_ready low 32 cycles; then LO=0xFFFFFFF1, HI=0xFFFFFFFF.
//  divu 7/0 -> LO=0xFFFFFFFF, HI=7; div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  mthi 0x55 then div 9/4, flush at busy cycle 5 -> in_ready=1 next cycle, mfhi returns 0x55.
//  reset asserted mid-mult and with in_valid=1 -> next cycle out_valid=0, HI=LO=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage ALU and the control unit:
//   - alu_op_e    : internal ALU operation selector
//   - alu_dec_t   : decoded operation (op + signedness + shift-source select)
//   - OP_* / FN_* : instruction opcode / funct field encodings
//   - alu_decode  : opcode/funct -> alu_dec_t
//   - alu_writes_gpr : whether an op produces a GPR result (out_valid)
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_LUI,
        ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO, ALU_MUL, ALU_DIV, ALU_NOP
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    sgn;        // signed compare / signed mult-div
        logic    var_shamt;  // shift amount comes from rs instead of shamt field
    } alu_dec_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    function automatic alu_dec_t alu_decode(input logic [5:0] opcode,
                                            input logic [5:0] funct);
        alu_dec_t d;
        d.op        = ALU_NOP;
        d.sgn       = 1'b0;
        d.var_shamt = 1'b0;
        case (opcode)
            OP_LW, OP_LB, OP_SW,
            OP_ADDI, OP_ADDIU: d.op = ALU_ADD;
            OP_ANDI:           d.op = ALU_AND;
            OP_SLTI:           begin d.op = ALU_SLT; d.sgn = 1'b1; end
            OP_SLTIU:          d.op = ALU_SLT;
            OP_LUI:            d.op = ALU_LUI;
            OP_BEQ:            d.op = ALU_SUB;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU,
                    FN_JR, FN_JALR:  d.op = ALU_ADD;
                    FN_SUB, FN_SUBU: d.op = ALU_SUB;
                    FN_AND:          d.op = ALU_AND;
                    FN_OR:           d.op = ALU_OR;
                    FN_XOR:          d.op = ALU_XOR;
                    FN_NOR:          d.op = ALU_NOR;
                    FN_SLT:          begin d.op = ALU_SLT; d.sgn = 1'b1; end
                    FN_SLTU:         d.op = ALU_SLT;
                    FN_SLL:          d.op = ALU_SLL;
                    FN_SRL:          d.op = ALU_SRL;
                    FN_SRA:          d.op = ALU_SRA;
                    FN_SLLV:         begin d.op = ALU_SLL; d.var_shamt = 1'b1; end
                    FN_SRLV:         begin d.op = ALU_SRL; d.var_shamt = 1'b1; end
                    FN_SRAV:         begin d.op = ALU_SRA; d.var_shamt = 1'b1; end
                    FN_MFHI:         d.op = ALU_MFHI;
                    FN_MFLO:         d.op = ALU_MFLO;
                    FN_MTHI:         d.op = ALU_MTHI;
                    FN_MTLO:         d.op = ALU_MTLO;
                    FN_MULT:         begin d.op = ALU_MUL; d.sgn = 1'b1; end
                    FN_MULTU:        d.op = ALU_MUL;
                    FN_DIV:          begin d.op = ALU_DIV; d.sgn = 1'b1; end
                    FN_DIVU:         d.op = ALU_DIV;
                    default:         d.op = ALU_NOP;
                endcase
            end
            default: d.op = ALU_NOP;
        endcase
        return d;
    endfunction

    // HI/LO-only ops complete silently; everything else (including NOP,
    // which returns zero) raises out_valid.
    function automatic logic alu_writes_gpr(input alu_op_e op);
        return !(op inside {ALU_MTHI, ALU_MTLO, ALU_MUL, ALU_DIV});
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// ----------------------------------------------------------------------------
// alu_exec_unit_if
// Issue/result bus of the EX-stage unit.
//   master : ID/EX side (drives operation, flush; sees in_ready and results)
//   slave  : alu_exec_unit
// Signals: flush, in_valid/in_ready handshake, in_opcode, in_funct,
//          in_shamt, in_a, in_b, out_valid, out_result, out_ovf.
// ----------------------------------------------------------------------------
interface alu_exec_unit_if #(parameter int WIDTH = 32);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         in_opcode;
    logic [5:0]         in_funct;
    logic [SHAMT_W-1:0] in_shamt;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               out_valid;
    logic [WIDTH-1:0]   out_result;
    logic               out_ovf;

    modport master (
        output flush, in_valid, in_opcode, in_funct, in_shamt, in_a, in_b,
        input  in_ready, out_valid, out_result, out_ovf
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_funct, in_shamt, in_a, in_b,
        output in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// ----------------------------------------------------------------------------
// alu_muldiv_iter
// Multi-cycle multiply/divide engine. Works on operand magnitudes and fixes
// signs on the final cycle.
//   start/is_signed/is_div/op_a/op_b : launch (only while !busy)
//   abort                             : drop the operation at the next edge
//   busy                              : operation in progress
//   done                              : last busy cycle; hi/lo valid now
//   hi/lo                             : mult {hi,lo}=product; div lo=quot, hi=rem
// MUL_ITER=1: shift-add multiply, WIDTH cycles. MUL_ITER=0: '*' in 1 cycle.
// Divide is always restoring division, WIDTH cycles.
// ----------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend->quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;       // |multiplicand| / |divisor|
    logic             neg_lo_q, neg_lo_d;   // negate product / quotient
    logic             neg_hi_q, neg_hi_d;   // negate remainder (dividend sign)
    logic             dz_q, dz_d;           // divide by zero

    logic             last;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   r_sh, r_sub;
    logic             ge;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [2*WIDTH-1:0] mul_mag, prod;

    // Multiply step: either one shift-add iteration or the whole product.
    if (MUL_ITER == 0) begin : g_mul_fast
        assign mul_hi_n = acc_hi_q;
        assign mul_lo_n = acc_lo_q;
        assign mul_mag  = (2*WIDTH)'(acc_lo_q) * (2*WIDTH)'(opnd_q);
    end else begin : g_mul_iter
        logic [WIDTH:0] sum;
        assign sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        assign mul_hi_n = sum[WIDTH:1];
        assign mul_lo_n = {sum[0], acc_lo_q[WIDTH-1:1]};
        assign mul_mag  = {mul_hi_n, mul_lo_n};
    end

    // Restoring division step: shift next dividend bit into the remainder.
    always_comb begin
        r_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
        r_sub    = r_sh - {1'b0, opnd_q};
        ge       = (r_sh >= {1'b0, opnd_q});
        div_hi_n = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
        div_lo_n = {acc_lo_q[WIDTH-2:0], ge};
    end

    assign last = (cnt_q == '0);
    assign busy = busy_q;
    assign done = busy_q && last && !abort;

    // Result sign fix-up; only meaningful while done.
    always_comb begin
        prod = neg_lo_q ? -mul_mag : mul_mag;
        hi   = prod[2*WIDTH-1:WIDTH];
        lo   = prod[WIDTH-1:0];
        if (is_div_q) begin
            // Magnitude division by zero already leaves rem=|dividend|,
            // so sign-restoring it yields the raw dividend in HI.
            hi = neg_hi_q ? -div_hi_n : div_hi_n;
            lo = dz_q ? '1 : (neg_lo_q ? -div_lo_n : div_lo_n);
        end
    end

    always_comb begin
        a_neg = is_signed & op_a[WIDTH-1];
        b_neg = is_signed & op_b[WIDTH-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;

        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;

        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = (!is_div && MUL_ITER == 0) ? '0 : CNT_W'(WIDTH - 1);
            acc_hi_d = '0;
            acc_lo_d = mag_a;
            opnd_d   = mag_b;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            dz_d     = (op_b == '0);
        end else if (busy_q) begin
            acc_hi_d = is_div_q ? div_hi_n : mul_hi_n;
            acc_lo_d = is_div_q ? div_lo_n : mul_lo_n;
            cnt_d    = cnt_q - 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end

        if (abort) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ----------------------------------------------------------------------------
// alu_exec_unit
// EX-stage unit: decodes opcode/funct, executes, registers the result
// (1-cycle latency). Owns HI/LO and the multi-cycle mult/div engine;
// in_ready drops while mult/div is busy so the hazard unit can stall.
// Ports:
//   clk, reset (sync, active high)
//   bus (alu_exec_unit_if.slave): flush, in_valid/in_ready, in_opcode,
//       in_funct, in_shamt, in_a, in_b, out_valid, out_result, out_ovf
// Build option: define ALU_OVF_EXC_EN to flag signed add/sub/addi overflow on
// out_ovf; otherwise out_ovf is constant 0.
// ----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input  logic               clk,
    input  logic               reset,
    alu_exec_unit_if.slave     bus
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_dec_t           dec;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               lt;
    logic               issue;
    logic               md_start, md_busy, md_done;
    logic [WIDTH-1:0]   md_hi, md_lo;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    assign bus.in_ready = !md_busy;
    // flush kills the issue even when the op is otherwise accepted.
    assign issue    = bus.in_valid && bus.in_ready && !bus.flush;
    assign md_start = issue && (dec.op == ALU_MUL || dec.op == ALU_DIV);

    always_comb begin
        dec     = alu_decode(bus.in_opcode, bus.in_funct);
        shamt   = dec.var_shamt ? bus.in_a[SHAMT_W-1:0] : bus.in_shamt;
        sum     = bus.in_a + bus.in_b;
        diff    = bus.in_a - bus.in_b;
        lt      = dec.sgn ? ($signed(bus.in_a) < $signed(bus.in_b))
                          : (bus.in_a < bus.in_b);
        alu_res = '0;
        case (dec.op)
            ALU_ADD:  alu_res = sum;
            ALU_SUB:  alu_res = diff;
            ALU_AND:  alu_res = bus.in_a & bus.in_b;
            ALU_OR:   alu_res = bus.in_a | bus.in_b;
            ALU_XOR:  alu_res = bus.in_a ^ bus.in_b;
            ALU_NOR:  alu_res = ~(bus.in_a | bus.in_b);
            ALU_SLL:  alu_res = bus.in_b << shamt;
            ALU_SRL:  alu_res = bus.in_b >> shamt;
            ALU_SRA:  alu_res = $signed(bus.in_b) >>> shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            ALU_LUI:  alu_res = {bus.in_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            default:  alu_res = '0;   // undecoded ops return zero
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH    (WIDTH),
        .MUL_ITER (MUL_ITER)
    ) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .abort     (bus.flush),
        .start     (md_start),
        .is_signed (dec.sgn),
        .is_div    (dec.op == ALU_DIV),
        .op_a      (bus.in_a),
        .op_b      (bus.in_b),
        .busy      (md_busy),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    always_comb begin
        out_valid_d  = issue && alu_writes_gpr(dec.op);
        out_result_d = out_valid_d ? alu_res : out_result_q;

        // mthi/mtlo cannot coincide with md_done: they need in_ready.
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (issue && dec.op == ALU_MTHI) begin
            hi_d = bus.in_a;
        end else if (issue && dec.op == ALU_MTLO) begin
            lo_d = bus.in_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;

`ifdef ALU_OVF_EXC_EN
    logic out_ovf_q, out_ovf_d;
    logic ovf_chk, ovf_add, ovf_sub;

    always_comb begin
        // Only the trapping forms: add, sub, addi.
        ovf_chk   = (bus.in_opcode == OP_ADDI) ||
                    (bus.in_opcode == OP_RTYPE &&
                     (bus.in_funct == FN_ADD || bus.in_funct == FN_SUB));
        ovf_add   = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
        ovf_sub   = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
        out_ovf_d = out_valid_d && ovf_chk &&
                    ((dec.op == ALU_ADD) ? ovf_add : ovf_sub);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ovf_q <= 1'b0;
        end else begin
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.out_ovf = out_ovf_q;
`else
    assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit (WIDTH=32, MUL_ITER=1).
// Expected out_ovf depends on whether ALU_OVF_EXC_EN is defined.
// ----------------------------------------------------------------------------
module tb_alu_exec_unit;

`ifdef ALU_OVF_EXC_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .MUL_ITER(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op for one cycle; returns 1 time unit after the issuing edge.
    task automatic drive(input logic [5:0] opc, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_funct  = fn;
        bus.in_shamt  = sh;
        bus.in_a      = a;
        bus.in_b      = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        $display("op opc=%02h fn=%02h sh=%0d a=%08h b=%08h -> valid=%0b result=%08h ovf=%0b ready=%0b",
                 opc, fn, sh, a, b, bus.out_valid, bus.out_result, bus.out_ovf, bus.in_ready);
    endtask

    // Wait until in_ready rises; busy cycles counted from the current cycle.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.in_ready && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h00;
        bus.in_funct  = 6'h20;
        bus.in_a      = 32'h7FFF_FFFF;
        bus.in_b      = 32'h1;
        @(posedge clk);
        #1;
        $display("reset cycle: valid=%0b result=%08h ovf=%0b ready=%0b",
                 bus.out_valid, bus.out_result, bus.out_ovf, bus.in_ready);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %08h want 0", bus.out_result); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", bus.out_ovf); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.in_ready); end
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_add_sub;
        drive(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL add_result: got %08h want 80000000", bus.out_result); end
        checks++; if (bus.out_ovf !== OVF_EXP) begin errors++; $display("FAIL add_ovf: got %0b want %0b", bus.out_ovf, OVF_EXP); end
        drive(6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1);
        checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL addu_result: got %08h want 80000000", bus.out_result); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL addu_ovf: got %0b want 0", bus.out_ovf); end
        drive(6'h00, 6'h22, 5'd0, 32'h5, 32'h7);
        checks++; if (bus.out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %08h want fffffffe", bus.out_result); end
        drive(6'h00, 6'h22, 5'd0, 32'h8000_0000, 32'h1);
        checks++; if (bus.out_result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_wrap_result: got %08h want 7fffffff", bus.out_result); end
        checks++; if (bus.out_ovf !== OVF_EXP) begin errors++; $display("FAIL sub_ovf: got %0b want %0b", bus.out_ovf, OVF_EXP); end
        drive(6'h08, 6'h3f, 5'd0, 32'h10, 32'hFFFF_FFFF);
        checks++; if (bus.out_result !== 32'hF) begin errors++; $display("FAIL addi_result: got %08h want 0000000f", bus.out_result); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL addi_ovf: got %0b want 0", bus.out_ovf); end
        drive(6'h23, 6'h00, 5'd0, 32'h1000, 32'h24);
        checks++; if (bus.out_result !== 32'h1024) begin errors++; $display("FAIL lw_addr: got %08h want 00001024", bus.out_result); end
    endtask

    task automatic test_logic;
        drive(6'h00, 6'h24, 5'd0, 32'hF0F0, 32'hFF00);
        checks++; if (bus.out_result !== 32'hF000) begin errors++; $display("FAIL and: got %08h want 0000f000", bus.out_result); end
        drive(6'h00, 6'h25, 5'd0, 32'hF0F0, 32'hFF00);
        checks++; if (bus.out_result !== 32'hFFF0) begin errors++; $display("FAIL or: got %08h want 0000fff0", bus.out_result); end
        drive(6'h00, 6'h26, 5'd0, 32'hF0F0, 32'hFF00);
        checks++; if (bus.out_result !== 32'h0FF0) begin errors++; $display("FAIL xor: got %08h want 00000ff0", bus.out_result); end
        drive(6'h00, 6'h27, 5'd0, 32'hF0F0, 32'hFF00);
        checks++; if (bus.out_result !== 32'hFFFF_000F) begin errors++; $display("FAIL nor: got %08h want ffff000f", bus.out_result); end
        drive(6'h0f, 6'h00, 5'd0, 32'hDEAD_BEEF, 32'hABCD_1234);
        checks++; if (bus.out_result !== 32'h1234_0000) begin errors++; $display("FAIL lui: got %08h want 12340000", bus.out_result); end
        drive(6'h0c, 6'h00, 5'd0, 32'h1234_5678, 32'h0000_00FF);
        checks++; if (bus.out_result !== 32'h78) begin errors++; $display("FAIL andi: got %08h want 00000078", bus.out_result); end
    endtask

    task automatic test_shift;
        drive(6'h00, 6'h00, 5'd4, 32'h0, 32'h1);
        checks++; if (bus.out_result !== 32'h10) begin errors++; $display("FAIL sll: got %08h want 00000010", bus.out_result); end
        drive(6'h00, 6'h02, 5'd31, 32'h0, 32'h8000_0000);
        checks++; if (bus.out_result !== 32'h1) begin errors++; $display("FAIL srl31: got %08h want 00000001", bus.out_result); end
        drive(6'h00, 6'h03, 5'd4, 32'h0, 32'h8000_0000);
        checks++; if (bus.out_result !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %08h want f8000000", bus.out_result); end
        drive(6'h00, 6'h07, 5'd0, 32'h4, 32'h8000_0000);
        checks++; if (bus.out_result !== 32'hF800_0000) begin errors++; $display("FAIL srav: got %08h want f8000000", bus.out_result); end
        drive(6'h00, 6'h06, 5'd0, 32'h24, 32'h8000_0000);
        checks++; if (bus.out_result !== 32'h0800_0000) begin errors++; $display("FAIL srlv: got %08h want 08000000", bus.out_result); end
        drive(6'h00, 6'h04, 5'd0, 32'h1F, 32'h3);
        checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL sllv: got %08h want 80000000", bus.out_result); end
    endtask

    task automatic test_slt;
        drive(6'h00, 6'h2b, 5'd0, 32'h1, 32'hFFFF_FFFF);
        checks++; if (bus.out_result !== 32'h1) begin errors++; $display("FAIL sltu: got %08h want 00000001", bus.out_result); end
        drive(6'h00, 6'h2a, 5'd0, 32'h5, 32'h5);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL slt_equal: got %08h want 00000000", bus.out_result); end
        drive(6'h00, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'h1);
        checks++; if (bus.out_result !== 32'h1) begin errors++; $display("FAIL slt_neg: got %08h want 00000001", bus.out_result); end
        drive(6'h0a, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h0);
        checks++; if (bus.out_result !== 32'h1) begin errors++; $display("FAIL slti: got %08h want 00000001", bus.out_result); end
        drive(6'h0b, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'h0);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL sltiu: got %08h want 00000000", bus.out_result); end
    endtask

    task automatic test_undecoded;
        drive(6'h00, 6'h25, 5'd0, 32'hAAAA_5555, 32'h0);
        drive(6'h3f, 6'h00, 5'd0, 32'h1234, 32'h5678);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL undec_valid: got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL undec_result: got %08h want 0", bus.out_result); end
        drive(6'h00, 6'h3f, 5'd0, 32'h1234, 32'h5678);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL undec_funct_result: got %08h want 0", bus.out_result); end
    endtask

    task automatic test_hilo_move;
        drive(6'h00, 6'h11, 5'd0, 32'hAA, 32'h0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mthi_valid: got %0b want 0", bus.out_valid); end
        drive(6'h00, 6'h13, 5'd0, 32'hBB, 32'h0);
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hAA) begin errors++; $display("FAIL mfhi_after_mthi: got %08h want 000000aa", bus.out_result); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hBB) begin errors++; $display("FAIL mflo_after_mtlo: got %08h want 000000bb", bus.out_result); end
    endtask

    task automatic test_back_to_back;
        drive(6'h00, 6'h20, 5'd0, 32'h1, 32'h2);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h3) begin errors++; $display("FAIL b2b_first: got valid=%0b %08h want valid=1 00000003", bus.out_valid, bus.out_result); end
        drive(6'h00, 6'h22, 5'd0, 32'h10, 32'h4);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hC) begin errors++; $display("FAIL b2b_second: got valid=%0b %08h want valid=1 0000000c", bus.out_valid, bus.out_result); end
        drive(6'h00, 6'h26, 5'd0, 32'hFF, 32'h0F);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hF0) begin errors++; $display("FAIL b2b_third: got valid=%0b %08h want valid=1 000000f0", bus.out_valid, bus.out_result); end
    endtask

    task automatic test_mult;
        int n;
        drive(6'h00, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'h5);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mult_valid: got %0b want 0", bus.out_valid); end
        wait_ready(n);
        checks++; if (n != 32) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 32", n); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %08h want fffffff1", bus.out_result); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %08h want ffffffff", bus.out_result); end
        drive(6'h00, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'h2);
        wait_ready(n);
        checks++; if (n != 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 32", n); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h1) begin errors++; $display("FAIL multu_hi: got %08h want 00000001", bus.out_result); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %08h want fffffffe", bus.out_result); end
    endtask

    task automatic test_div;
        int n;
        drive(6'h00, 6'h1b, 5'd0, 32'h7, 32'h0);
        wait_ready(n);
        checks++; if (n != 32) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 32", n); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %08h want ffffffff", bus.out_result); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h7) begin errors++; $display("FAIL divu0_hi: got %08h want 00000007", bus.out_result); end
        drive(6'h00, 6'h1a, 5'd0, 32'hFFFF_FFF9, 32'h2);
        wait_ready(n);
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %08h want fffffffd", bus.out_result); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %08h want ffffffff", bus.out_result); end
        drive(6'h00, 6'h1a, 5'd0, 32'hFFFF_FFF9, 32'h0);
        wait_ready(n);
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_signed_lo: got %08h want ffffffff", bus.out_result); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div0_signed_hi: got %08h want fffffff9", bus.out_result); end
        drive(6'h00, 6'h1a, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_ready(n);
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo: got %08h want 80000000", bus.out_result); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL divmin_hi: got %08h want 00000000", bus.out_result); end
    endtask

    task automatic test_flush;
        // flush beats in_valid on an otherwise accepted op
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h00;
        bus.in_funct  = 6'h20;
        bus.in_a      = 32'h1;
        bus.in_b      = 32'h1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        $display("flushed add: valid=%0b result=%08h", bus.out_valid, bus.out_result);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_issue_valid: got %0b want 0", bus.out_valid); end

        drive(6'h00, 6'h11, 5'd0, 32'h55, 32'h0);
        drive(6'h00, 6'h1a, 5'd0, 32'h9, 32'h4);   // now in busy cycle 1
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_busy_before: got ready=%0b want 0", bus.in_ready); end
        @(negedge clk);
        bus.flush = 1'b1;                            // busy cycle 5
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        $display("flush during div: ready=%0b", bus.in_ready);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_abort_ready: got %0b want 1", bus.in_ready); end
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h55) begin errors++; $display("FAIL flush_hi_kept: got %08h want 00000055", bus.out_result); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h8000_0000) begin errors++; $display("FAIL flush_lo_kept: got %08h want 80000000", bus.out_result); end
    endtask

    task automatic test_reset_mid;
        drive(6'h00, 6'h18, 5'd0, 32'h1234, 32'h5678);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_opcode = 6'h00;
        bus.in_funct  = 6'h20;
        bus.in_a      = 32'h3;
        bus.in_b      = 32'h4;
        @(posedge clk);
        #1;
        $display("reset mid-mult: valid=%0b ready=%0b", bus.out_valid, bus.in_ready);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b want 1", bus.in_ready); end
        @(negedge clk);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %08h want 0", bus.out_result); end
        drive(6'h00, 6'h12, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %08h want 0", bus.out_result); end
        // engine must stay idle afterwards: a stale completion would disturb HI/LO
        repeat (40) @(posedge clk);
        #1;
        drive(6'h00, 6'h10, 5'd0, 32'h0, 32'h0);
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL rstmid_hi_later: got %08h want 0", bus.out_result); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_funct  = '0;
        bus.in_shamt  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        repeat (2) @(posedge clk);

        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_slt();
        test_undecoded();
        test_hilo_move();
        test_back_to_back();
        test_mult();
        test_div();
        test_flush();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
